// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared types, Funct3 encodings and helpers for the MEM-stage
// load/store responder (data_mem_ctrl) and its lane aligner (mem_lane_align).
package data_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Access size lives in funct3[1:0]; 2'b10 and 2'b11 both act as a word,
  // which is what makes the unused encodings 011/110/111 behave as lw.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  function automatic logic [3:0] be_of(input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
    case (funct3[1:0])
      SZ_BYTE: be_of = 4'b0001 << addr_lo;
      SZ_HALF: be_of = 4'b0011 << addr_lo;
      default: be_of = 4'b1111;
    endcase
  endfunction

  function automatic logic is_aligned(input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
    case (funct3[1:0])
      SZ_BYTE: is_aligned = 1'b1;
      SZ_HALF: is_aligned = ~addr_lo[0];
      default: is_aligned = (addr_lo == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane handling.
//   st_funct3_i, st_data_i -> st_lane_o : store data replicated across lanes
//   ld_funct3_i, ld_addr_lo_i, ld_rdata_i -> ld_data_o : selected lane,
//   sign-extended for lb/lh (funct3[2]=0), zero-extended for lbu/lhu.
module mem_lane_align
  import data_mem_pkg::*;
(
  input  logic [2:0]  st_funct3_i,
  input  logic [31:0] st_data_i,
  output logic [31:0] st_lane_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_addr_lo_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] shifted;
  logic        sext;

  always_comb begin
    st_lane_o = st_data_i;
    case (st_funct3_i[1:0])
      SZ_BYTE: st_lane_o = {4{st_data_i[7:0]}};
      SZ_HALF: st_lane_o = {2{st_data_i[15:0]}};
      default: st_lane_o = st_data_i;
    endcase
  end

  always_comb begin
    shifted   = ld_rdata_i >> {ld_addr_lo_i, 3'b000};
    sext      = ~ld_funct3_i[2];
    ld_data_o = ld_rdata_i;
    case (ld_funct3_i[1:0])
      SZ_BYTE: ld_data_o = {{24{sext & shifted[7]}}, shifted[7:0]};
      SZ_HALF: ld_data_o = {{16{sext & shifted[15]}}, shifted[15:0]};
      default: ld_data_o = ld_rdata_i;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: MEM-stage load/store responder between the execute result
// and a single-port req/ready data bus.
//   Control in : MemRead, MemWrite, RegWrite, MemtoReg, Funct3, Addr, WData, Rd
//   Pipeline   : Stall (holds upstream while an access is outstanding)
//   Bus        : BusReq/BusWe/BusAddr/BusBe/BusWData out, BusReady/BusRData in
//   Write-back : WbValid (one-cycle strobe), WbData, WbRd
//   Error      : AccessErr (one-cycle pulse: misaligned, conflicting, timed out)
//
// state | meaning
// IDLE  | waiting for a load/store; legal request latched, moves to REQ
// REQ   | BusReq held with stable bus outputs until BusReady or timeout
// DONE  | single cycle; WbValid for loads that write a register
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              RegWrite,
  input  logic              MemtoReg,
  input  logic [2:0]        Funct3,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [31:0]       WData,
  input  logic [4:0]        Rd,
  output logic              Stall,
  output logic              BusReq,
  output logic              BusWe,
  output logic [ADDR_W-1:0] BusAddr,
  output logic [3:0]        BusBe,
  output logic [31:0]       BusWData,
  input  logic              BusReady,
  input  logic [31:0]       BusRData,
  output logic              WbValid,
  output logic [31:0]       WbData,
  output logic [4:0]        WbRd,
  output logic              AccessErr
);

  localparam logic [TO_W-1:0] TO_LIM  = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0] CNT_ONE = TO_W'(1);

  state_e             state_q, state_d;
  logic [TO_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [3:0]         be_q, be_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [2:0]         f3_q, f3_d;
  logic [1:0]         alo_q, alo_d;
  logic [4:0]         rd_q, rd_d;
  logic               regwr_q, regwr_d;
  logic               m2r_q, m2r_d;
  logic [31:0]        wbdata_q, wbdata_d;
  logic               err_q, err_d;

  logic [31:0]        st_lane, ld_data;
  logic               req_any, conflict, legal;

  assign req_any  = MemRead | MemWrite;
  assign conflict = MemRead & MemWrite;
  assign legal    = req_any & ~conflict & is_aligned(Funct3, Addr[1:0]);
  assign cnt_inc  = cnt_q + CNT_ONE;

  mem_lane_align u_align (
    .st_funct3_i  (Funct3),
    .st_data_i    (WData),
    .st_lane_o    (st_lane),
    .ld_funct3_i  (f3_q),
    .ld_addr_lo_i (alo_q),
    .ld_rdata_i   (BusRData),
    .ld_data_o    (ld_data)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    f3_d     = f3_q;
    alo_d    = alo_q;
    rd_d     = rd_q;
    regwr_d  = regwr_q;
    m2r_d    = m2r_q;
    wbdata_d = wbdata_q;
    err_d    = 1'b0;
    Stall    = 1'b0;
    WbValid  = 1'b0;

    case (state_q)
      IDLE: begin
        if (legal) begin
          // Stall must rise in the request cycle itself so the upstream
          // stages freeze before the bus handshake starts.
          Stall   = 1'b1;
          we_d    = MemWrite;
          addr_d  = {Addr[ADDR_W-1:2], 2'b00};
          be_d    = be_of(Funct3, Addr[1:0]);
          wdata_d = st_lane;
          f3_d    = Funct3;
          alo_d   = Addr[1:0];
          rd_d    = Rd;
          regwr_d = RegWrite;
          m2r_d   = MemtoReg;
          cnt_d   = '0;
          state_d = REQ;
        end else if (req_any) begin
          err_d = 1'b1;
        end
      end

      REQ: begin
        Stall = 1'b1;
        if (BusReady) begin
          if (!we_q) wbdata_d = ld_data;
          state_d = DONE;
        end else if (cnt_inc == TO_LIM) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      DONE: begin
        WbValid = regwr_q & m2r_q & ~we_q;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      f3_q     <= '0;
      alo_q    <= '0;
      rd_q     <= '0;
      regwr_q  <= 1'b0;
      m2r_q    <= 1'b0;
      wbdata_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      f3_q     <= f3_d;
      alo_q    <= alo_d;
      rd_q     <= rd_d;
      regwr_q  <= regwr_d;
      m2r_q    <= m2r_d;
      wbdata_q <= wbdata_d;
      err_q    <= err_d;
    end
  end

  assign BusReq    = (state_q == REQ);
  assign BusWe     = we_q;
  assign BusAddr   = addr_q;
  assign BusBe     = be_q;
  assign BusWData  = wdata_q;
  assign WbData    = wbdata_q;
  assign WbRd      = rd_q;
  assign AccessErr = err_q;

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Load/store responder for the control lines produced by the main decoder (MemRead, MemWrite, MemtoReg, RegWrite). It sits in the MEM stage between the execute result and a single-port data-memory bus with a req/ready handshake. It steers bytes, generates byte enables, sign- or zero-extends load data, stalls the pipeline while an access is outstanding, and returns write-back data.

Parameters:
ADDR_W, 32, data-bus address width.
TIMEOUT, 255, maximum cycles to wait for BusReady before aborting (1..2^TO_W-1).
TO_W, 8, width of the timeout counter.

Ports:
Clk  in  1  clock; all logic on posedge.
Rst  in  1  reset; synchronous, active-high.
MemRead  in  1  load request from control.
MemWrite  in  1  store request from control.
RegWrite  in  1  instruction writes rd.
MemtoReg  in  1  write-back source: 1 = memory, 0 = ALU.
Funct3  in  3  access size/sign: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
Addr  in  ADDR_W  ALU result (effective address).
WData  in  32  store data (rs2).
Rd  in  5  destination register.
Stall  out  1  hold upstream stages.
BusReq  out  1  bus request; held until BusReady.
BusWe  out  1  1 = write.
BusAddr  out  ADDR_W  word-aligned address ({Addr[ADDR_W-1:2],2'b00}).
BusBe  out  4  byte enables.
BusWData  out  32  lane-steered store data.
BusReady  in  1  bus completes the access this cycle.
BusRData  in  32  read data, valid when BusReady is high on a read.
WbValid  out  1  one-cycle write-back strobe.
WbData  out  32  write-back value.
WbRd  out  5  write-back register.
AccessErr  out  1  one-cycle pulse: misaligned, conflicting, or timed-out access.

Behaviour:
- States: IDLE, REQ, DONE.
- Reset: state=IDLE. Stall, BusReq, BusWe, WbValid and AccessErr are 0. BusAddr, BusBe, BusWData, WbData, WbRd and the timeout counter are 0.
- A synchronous reset during REQ drops BusReq in the next cycle with no completion. The bus must tolerate an abandoned request.
- Legal request in IDLE: exactly one of MemRead or MemWrite is high, and the address is aligned:
  - word: Addr[1:0]==0
  - half: Addr[0]==0
  - byte: any alignment
- IDLE with a legal request:
  - Stall=1 combinationally in the same cycle.
  - Latch BusWe, BusAddr, BusBe, BusWData, Funct3, Addr[1:0], Rd, RegWrite and MemtoReg.
  - Go to REQ; the counter is cleared.
- IDLE with MemRead and MemWrite both high, or a misaligned address:
  - AccessErr=1 in the next cycle; no bus access; Stall stays 0; remain in IDLE.
- IDLE with no request: when RegWrite=1 and MemtoReg=0, there is no action. ALU write-back bypasses this block.
- Byte enables:
  - byte: 0001 << Addr[1:0]
  - half: 0011 << Addr[1:0]
  - word: 1111
- Store data: WData low byte or halfword replicated across lanes.
- Funct3 values 011, 110 and 111 are treated as lw.
- REQ:
  - BusReq=1, Stall=1; bus outputs are stable.
  - BusReady=1: latch the lane-extracted BusRData (sign-extended for lb/lh, zero-extended for lbu/lhu) and go to DONE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT: AccessErr=1 in the next cycle, go to IDLE, WbValid is not asserted.
- DONE (one cycle):
  - BusReq=0, Stall=0.
  - WbValid = latched RegWrite & latched MemtoReg & read; stores never assert WbValid.
  - WbRd = latched Rd. A load to x0 still strobes WbValid; the register file discards it.
  - Go to IDLE. A new request is not accepted in DONE.
- Latency: from request cycle t, BusReq at t+1. BusReady at t+1 gives DONE and WbValid at t+2, and Stall low at t+2. Each wait cycle adds one.
- WbData holds its value until the next load completes.

Decomposition:
- Package data_mem_pkg:
  - state enum {IDLE, REQ, DONE}
  - Funct3 constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU
  - function be_of(funct3, addr_lo)
- Sub-module mem_lane_align: combinational store-lane steering and load extract/extend. The FSM stays in data_mem_ctrl.

Test Plan:
- sw Addr=0x104, WData=0xDEADBEEF, BusReady at t+1 -> BusAddr=0x104, BusBe=1111, BusWe=1, BusWData=0xDEADBEEF, Stall high t..t+1, WbValid never.
- lb Addr=0x203, BusRData=0x80FF_0000, RegWrite=MemtoReg=1, Rd=5 -> WbData=0xFFFFFF80, WbRd=5, WbValid at t+2. Same case with lbu -> 0x00000080.
- sh Addr=0x302, WData=0x1234ABCD -> BusBe=1100, BusWData=0xABCDABCD. lh Addr=0x301 -> AccessErr at t+1, no BusReq.
- lw with BusReady delayed 3 cycles -> BusReq and outputs stable for 4 cycles, WbValid at t+5. BusReady never -> AccessErr after TIMEOUT cycles, returns to IDLE.
- MemRead and MemWrite both high -> AccessErr pulse, no bus access. Rst asserted mid-REQ -> BusReq=0 and all outputs at reset values next cycle.
